// File: rtl/pll_freq_meter_pkg.sv
// Shared types and defaults for the multi-channel PLL frequency meter.
package pll_freq_meter_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, LATCH} state_t;

    localparam int DEF_NCH         = 6;
    localparam int DEF_CNT_W       = 24;
    localparam int DEF_GATE_CYCLES = 1000000;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HB_BIT      = 21;

    function automatic int gate_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pll_freq_meter_ch.sv
// One measured channel: synchroniser, rising-edge detect, saturating gate counter, heartbeat.
module pll_freq_meter_ch
    import pll_freq_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HB_BIT      = DEF_HB_BIT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clk_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt_d,
    output logic             sat_d,
    output logic             hb
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic                   sat;
    logic [HB_BIT:0]        hb_cnt;

    assign rise = sync[SYNC_STAGES-1] & ~hist;
    assign hb   = hb_cnt[HB_BIT];

    // cnt_d is exported so the top can latch the count including an edge on the last gate cycle
    always_comb begin
        cnt_d = cnt;
        sat_d = sat;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (en && rise) begin
            if (&cnt) sat_d = 1'b1;
            else      cnt_d = cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync   <= '0;
            hist   <= 1'b0;
            cnt    <= '0;
            sat    <= 1'b0;
            hb_cnt <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], clk_in};
            hist <= sync[SYNC_STAGES-1];
            cnt  <= cnt_d;
            sat  <= sat_d;
            if (rise) hb_cnt <= hb_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pll_freq_meter.sv
// Frequency meter for NCH asynchronous PLL outputs against CLK over a fixed gate window.
// Optional continuous mode: define PLL_FREQ_METER_CONT_EN.
module pll_freq_meter
    import pll_freq_meter_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HB_BIT      = DEF_HB_BIT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NCH-1:0]       I_CLKS,
    input  logic                 I_LOCKED,
    input  logic                 I_START,
    output logic                 O_BUSY,
    output logic                 O_VALID,
    output logic                 O_ERR,
    output logic [NCH*CNT_W-1:0] O_COUNT,
    output logic [NCH-1:0]       O_SAT,
    output logic [NCH-1:0]       O_HB
);

    localparam int GW = gate_cnt_w(GATE_CYCLES);
    localparam int SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SYNC_STAGES);
    localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);

    state_t                     state, state_nxt;
    logic                       err_nxt;
    logic [SYNC_STAGES-1:0]     lock_sync;
    logic                       lock_s;
    logic [SW-1:0]              settle_cnt;
    logic [GW-1:0]              gate_cnt;
    logic [NCH-1:0][CNT_W-1:0]  ch_cnt;
    logic [NCH-1:0]             ch_sat;
    logic                       latch_now;

    assign lock_s    = lock_sync[SYNC_STAGES-1];
    assign O_BUSY    = (state != IDLE);
    assign latch_now = (state == GATE) && (state_nxt == LATCH);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pll_freq_meter_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .HB_BIT      (HB_BIT)
        ) u_ch (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .clk_in (I_CLKS[i]),
            .clr    (state == SETTLE),
            .en     (state == GATE),
            .cnt_d  (ch_cnt[i]),
            .sat_d  (ch_sat[i]),
            .hb     (O_HB[i])
        );
    end

`ifdef PLL_FREQ_METER_CONT_EN
    logic unused_start;
    assign unused_start = I_START;
`endif

    // Lock loss is checked before gate completion so abort wins on the last gate cycle
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
`ifdef PLL_FREQ_METER_CONT_EN
                if (lock_s) state_nxt = SETTLE;
`else
                if (I_START) begin
                    if (lock_s) state_nxt = SETTLE;
                    else        err_nxt   = 1'b1;
                end
`endif
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = GATE;
                end
            end
            GATE: begin
                if (!lock_s) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (gate_cnt == GATE_LAST) begin
                    state_nxt = LATCH;
                end
            end
            LATCH: begin
`ifdef PLL_FREQ_METER_CONT_EN
                state_nxt = lock_s ? SETTLE : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            lock_sync  <= '0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            O_VALID    <= 1'b0;
            O_ERR      <= 1'b0;
            O_COUNT    <= '0;
            O_SAT      <= '0;
        end else begin
            state      <= state_nxt;
            lock_sync  <= {lock_sync[SYNC_STAGES-2:0], I_LOCKED};
            settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
            gate_cnt   <= (state == GATE)   ? gate_cnt + 1'b1   : '0;
            O_ERR      <= err_nxt;
            O_VALID    <= latch_now;
            if (latch_now) begin
                O_COUNT <= ch_cnt;
                O_SAT   <= ch_sat;
            end
        end
    end

endmodule
